parity_gen_chk: RTL and testbench
=================================

PARITY_GEN_CHK -- requirements
Module: parity_gen_chk

Interface
REQ-001 The block SHALL have parameter DATA_W, default 9, meaning payload width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning error-counter width in bits (legal range 1..32).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  upstream word present.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-007 The block SHALL have port in_data  input  DATA_W  payload word.
REQ-008 The block SHALL have port in_par  input  1  received parity bit; used in check mode only.
REQ-009 The block SHALL have port mode_odd  input  1  parity sense: 0 = even, 1 = odd.
REQ-010 The block SHALL have port mode_chk  input  1  operation: 0 = generate, 1 = check.
REQ-011 The block SHALL have port out_valid  output  1  output word present.
REQ-012 The block SHALL have port out_ready  input  1  downstream accepts output word.
REQ-013 The block SHALL have port out_data  output  DATA_W  registered copy of accepted in_data.
REQ-014 The block SHALL have port out_par  output  1  parity bit computed for out_data.
REQ-015 The block SHALL have port out_err  output  1  parity mismatch flag for out_data.
REQ-016 The block SHALL have port err_cnt  output  CNT_W  saturating count of check-mode mismatches.
REQ-017 The block SHALL have port err_sticky  output  1  set on any mismatch; cleared only by cnt_clr or reset.
REQ-018 The block SHALL have port cnt_clr  input  1  synchronous clear of err_cnt and err_sticky.

Function
REQ-019 The block SHALL accept a word when in_valid and in_ready are both 1 on a rising clk edge (accept event).
REQ-020 The block SHALL hold one output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-021 The block SHALL drive in_ready = (out_valid == 0) or (out_ready == 1), combinationally.
REQ-022 Transitions: EMPTY->FULL on accept; FULL->EMPTY on out_ready without accept; FULL->FULL on out_ready with accept (new word loaded); FULL held with all outputs stable while out_ready=0.
REQ-023 Latency SHALL be exactly 1 cycle: a word accepted at edge N is on out_* after edge N; full throughput of 1 word/cycle when out_ready stays 1.
REQ-024 The computed parity SHALL be p = XOR of all DATA_W bits of in_data, XOR mode_odd, using mode_odd and mode_chk sampled at the accept edge.
REQ-025 Generate mode: out_par = p and out_err = 0.
REQ-026 Check mode: out_par = p and out_err = (p != in_par).
REQ-027 err_cnt SHALL increment by 1 on each accept with mode_chk=1 and mismatch, saturating at 2^CNT_W-1 (no wrap).
REQ-028 err_sticky SHALL set on the same event as REQ-027, including when err_cnt is saturated.
REQ-029 cnt_clr=1 SHALL force err_cnt=0 and err_sticky=0 at the next edge, with priority over a simultaneous mismatch (result 0 and 0).
REQ-030 cnt_clr SHALL NOT affect out_valid, out_data, out_par, out_err, or the handshake.
REQ-031 Mode inputs changing while FULL SHALL NOT alter the held output word.

Reset
REQ-032 rst_n=0 SHALL asynchronously force out_valid=0, out_data=0, out_par=0, out_err=0, err_cnt=0, err_sticky=0; in_ready then reads 1.
REQ-033 A word held in FULL when reset asserts SHALL be discarded; the first edge after rst_n deasserts SHALL be able to accept a word.

Verification
REQ-034 The bench SHALL cover: DATA_W=9, generate, even, in_data=9'h1FF -> next cycle out_valid=1, out_par=1, out_err=0; same with mode_odd=1 -> out_par=0.
REQ-035 The bench SHALL cover: check, even, in_data=9'h003, in_par=1 -> out_err=1, err_cnt=1, err_sticky=1; then in_par=0 -> out_err=0, err_cnt stays 1.
REQ-036 The bench SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first accept, out_data stable, no second word accepted; out_ready=1 -> back-to-back words delivered in order.
REQ-037 The bench SHALL cover: CNT_W=8, 300 consecutive check mismatches -> err_cnt=255 (8'hFF), err_sticky=1; then cnt_clr asserted together with a mismatch -> err_cnt=0, err_sticky=0.
REQ-038 The bench SHALL cover: rst_n pulsed low mid-cycle while FULL with err_cnt=5 -> out_valid=0, err_cnt=0 immediately, without waiting for a clk edge; in_ready=1 after release.
REQ-039 The bench SHALL cover: DATA_W=1 and DATA_W=64 builds, comparing out_par against a reference XOR for 1000 random words in each mode.

Source files
------------

// File: rtl/parity_gen_chk.sv
// parity_gen_chk
//   One-deep registered parity stage with a valid/ready handshake on both sides.
//   Generate mode stamps each accepted word with a parity bit; check mode also
//   compares that bit against the received in_par and flags or counts mismatches.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_data, in_par payload + received parity
//   mode_odd, mode_chk  parity sense (0 even / 1 odd), operation (0 gen / 1 check)
//   out_valid/out_ready downstream handshake; out_data, out_par, out_err result
//   err_cnt, err_sticky saturating mismatch count and sticky flag
//   cnt_clr             synchronous clear of err_cnt / err_sticky
module parity_gen_chk #(
  parameter int DATA_W = 9,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              mode_odd,
  input  logic              mode_chk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_sticky,
  input  logic              cnt_clr
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              par;
    logic              err;
  } rsp_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  rsp_t             rsp_q;
  logic             vld_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stk_q;
  logic             accept;
  logic             par_calc;
  logic             mism;

  // The slot frees up in the same cycle it is drained, so a full stage still
  // sustains one word per cycle while out_ready stays high.
  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Modes are only looked at here, on the accept edge; a held word keeps the
  // parity/error it was captured with regardless of later mode changes.
  assign par_calc = (^in_data) ^ mode_odd;
  assign mism     = mode_chk && (par_calc != in_par);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      rsp_q <= '0;
    end else if (accept) begin
      vld_q      <= 1'b1;
      rsp_q.data <= in_data;
      rsp_q.par  <= par_calc;
      rsp_q.err  <= mism;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  // Clear wins over a simultaneous mismatch; sticky still sets once the
  // counter has saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      stk_q <= 1'b0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
      stk_q <= 1'b0;
    end else if (accept && mism) begin
      stk_q <= 1'b1;
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid  = vld_q;
  assign out_data   = rsp_q.data;
  assign out_par    = rsp_q.par;
  assign out_err    = rsp_q.err;
  assign err_cnt    = cnt_q;
  assign err_sticky = stk_q;

endmodule

// File: tb/tb_parity_gen_chk.sv
// Bench for parity_gen_chk: three builds (DATA_W = 9, 1, 64) share one stimulus
// stream. Each build has its own cycle-level reference model that pushes the
// expected word into a queue on accept, and a negedge monitor that checks the
// handshake, counters and the presented word against the queue head.
module tb_parity_gen_chk;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_par = 1'b0;
  logic        mode_odd = 1'b0;
  logic        mode_chk = 1'b0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;

  logic [2:0]       in_rdy;
  logic [2:0]       o_valid;
  logic [2:0][63:0] o_data;
  logic [2:0]       o_par;
  logic [2:0]       o_err;
  logic [2:0][7:0]  o_cnt;
  logic [2:0]       o_stk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] d;
    logic        p;
    logic        e;
  } exp_t;

  always #5 clk = ~clk;

  task automatic check(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[inst%0d] t=%0t got %h want %h", nm, k, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 9 : (g == 1) ? 1 : 64;

    logic [W-1:0] od;

    parity_gen_chk #(.DATA_W(W), .CNT_W(8)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_rdy[g]),
      .in_data    (in_data[W-1:0]),
      .in_par     (in_par),
      .mode_odd   (mode_odd),
      .mode_chk   (mode_chk),
      .out_valid  (o_valid[g]),
      .out_ready  (out_ready),
      .out_data   (od),
      .out_par    (o_par[g]),
      .out_err    (o_err[g]),
      .err_cnt    (o_cnt[g]),
      .err_sticky (o_stk[g]),
      .cnt_clr    (cnt_clr)
    );

    assign o_data[g] = 64'(od);

    // Reference model: occupancy flag, integer error count, expected-word queue.
    logic        m_full = 1'b0;
    int          m_cnt = 0;
    logic        m_stk = 1'b0;
    exp_t        q[$];
    logic        m_acc, m_p, m_mis;
    logic [63:0] m_d;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_full = 1'b0;
        m_cnt  = 0;
        m_stk  = 1'b0;
        q.delete();
      end else begin
        m_acc = in_valid && (!m_full || out_ready);
        m_d   = 64'(in_data[W-1:0]);
        m_p   = 1'(($countones(m_d) + int'(mode_odd)) % 2);
        m_mis = mode_chk && (m_p != in_par);
        if (m_acc) q.push_back('{m_d, m_p, m_mis});
        if (cnt_clr) begin
          m_cnt = 0;
          m_stk = 1'b0;
        end else if (m_acc && m_mis) begin
          m_stk = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
        if (m_acc) m_full = 1'b1;
        else if (out_ready) m_full = 1'b0;
      end
    end

    always @(negedge clk) begin
      check("in_ready", g, 64'(in_rdy[g]), 64'(!m_full || out_ready));
      check("out_valid", g, 64'(o_valid[g]), 64'(m_full));
      check("err_cnt", g, 64'(o_cnt[g]), 64'(m_cnt));
      check("err_sticky", g, 64'(o_stk[g]), 64'(m_stk));
      if (o_valid[g]) begin
        check("sb_depth", g, 64'(q.size()), 64'd1);
        if (q.size() > 0) begin
          check("out_data", g, o_data[g], q[0].d);
          check("out_par", g, 64'(o_par[g]), 64'(q[0].p));
          check("out_err", g, 64'(o_err[g]), 64'(q[0].e));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [63:0] d, input logic par, input logic odd,
                     input logic chk, input logic ordy, input logic clr);
    in_valid  = v;
    in_data   = d;
    in_par    = par;
    mode_odd  = odd;
    mode_chk  = chk;
    out_ready = ordy;
    cnt_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    for (int k = 0; k < 3; k++) begin
      check("rst_out_valid", k, 64'(o_valid[k]), 64'd0);
      check("rst_in_ready", k, 64'(in_rdy[k]), 64'd1);
      check("rst_err_cnt", k, 64'(o_cnt[k]), 64'd0);
      check("rst_out_data", k, o_data[k], 64'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Generate mode, even then odd, on 9'h1FF
    cyc(1, 64'h1FF, 0, 0, 0, 1, 0);
    check("gen_even_valid", 0, 64'(o_valid[0]), 64'd1);
    check("gen_even_par", 0, 64'(o_par[0]), 64'd1);
    check("gen_even_err", 0, 64'(o_err[0]), 64'd0);
    cyc(1, 64'h1FF, 0, 1, 0, 1, 0);
    check("gen_odd_par", 0, 64'(o_par[0]), 64'd0);

    // Check mode, even: 9'h003 with in_par=1 mismatches, then in_par=0 matches
    cyc(1, 64'h003, 1, 0, 1, 1, 0);
    check("chk_mis_err", 0, 64'(o_err[0]), 64'd1);
    check("chk_mis_cnt", 0, 64'(o_cnt[0]), 64'd1);
    check("chk_mis_stk", 0, 64'(o_stk[0]), 64'd1);
    cyc(1, 64'h003, 0, 0, 1, 1, 0);
    check("chk_ok_err", 0, 64'(o_err[0]), 64'd0);
    check("chk_ok_cnt", 0, 64'(o_cnt[0]), 64'd1);

    // Backpressure: drain, accept A, stall 3 cycles offering B, then stream
    cyc(0, 64'h0, 0, 0, 0, 1, 0);
    cyc(1, 64'h0A5, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", 0, 64'(in_rdy[0]), 64'd0);
      check("stall_data", 0, o_data[0], 64'h0A5);
      cyc(1, 64'h15A, 0, i[0], 1, 0, 0);
    end
    check("stall_data_end", 0, o_data[0], 64'h0A5);
    cyc(1, 64'h15A, 0, 0, 0, 1, 0);
    check("b2b_word_b", 0, o_data[0], 64'h15A);
    cyc(1, 64'h0C3, 0, 0, 0, 1, 0);
    check("b2b_word_c", 0, o_data[0], 64'h0C3);

    // Randomized traffic across all modes, backpressure and occasional clears
    for (int i = 0; i < 6000; i++)
      cyc($urandom_range(0, 9) < 8, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
          1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);

    // Saturation: 300 back-to-back mismatches (data 0, even, in_par 1)
    for (int i = 0; i < 300; i++) cyc(1, 64'h0, 1, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      check("sat_cnt", k, 64'(o_cnt[k]), 64'hFF);
      check("sat_stk", k, 64'(o_stk[k]), 64'd1);
    end
    cyc(1, 64'h0, 1, 0, 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      check("clr_cnt", k, 64'(o_cnt[k]), 64'd0);
      check("clr_stk", k, 64'(o_stk[k]), 64'd0);
      check("clr_keeps_word", k, 64'(o_valid[k]), 64'd1);
    end

    // Async reset while FULL with err_cnt=5
    for (int i = 0; i < 5; i++) cyc(1, 64'h0, 1, 0, 1, 1, 0);
    cyc(0, 64'h0, 0, 0, 0, 0, 0);
    check("pre_rst_cnt", 0, 64'(o_cnt[0]), 64'd5);
    check("pre_rst_valid", 0, 64'(o_valid[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("async_rst_valid", k, 64'(o_valid[k]), 64'd0);
      check("async_rst_cnt", k, 64'(o_cnt[k]), 64'd0);
      check("async_rst_stk", k, 64'(o_stk[k]), 64'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 0, 64'(in_rdy[0]), 64'd1);
    cyc(1, 64'h101, 0, 0, 0, 0, 0);
    check("post_rst_accept", 0, 64'(o_valid[0]), 64'd1);
    check("post_rst_data", 0, o_data[0], 64'h101);
    cyc(0, 64'h0, 0, 0, 0, 1, 0);
    cyc(0, 64'h0, 0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
